// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-FF sync, 3-sample majority vote, parity/framing/break flags, output FIFO.
// Entry visible 1 clk after the final stop mid-bit decision; when the FIFO is full and not popping, the frame is dropped with a one-cycle rx_overrun.
module uart_rx_cfg #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_perr,
  output logic                 m_ferr,
  output logic                 m_brk,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 rx_busy,
  output logic                 rx_overrun
);
  localparam int PH_W = $clog2(OVERSAMPLE);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int EW   = DATA_BITS + 3;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP1, S_STOP2} state_t;

  logic                 rxd_m_q, rxd_s_q, rxd_p_q;
  state_t               state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d, cnt_q, cnt_d, div_eff;
  logic [PH_W-1:0]      ph_q, ph_d;
  logic [1:0]           smp_q, smp_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic [3:0]           bcnt_q, bcnt_d;
  logic                 par_q, par_d, perr_q, perr_d, ferr_q, ferr_d, brk_q, brk_d;
  logic [AW:0]          wr_q, wr_d, rd_q, rd_d;
  logic [EW-1:0]        mem_q [FIFO_DEPTH];
  logic [EW-1:0]        mem_d [FIFO_DEPTH];
  logic [EW-1:0]        entry, head;
  logic                 start_edge, tick, smp_a, smp_b, mid, eob, vote;
  logic                 push_req, push, pop, full, empty, brk_now;

  assign div_eff    = (baud_div > DIV_W'(1)) ? baud_div : DIV_W'(1);
  assign start_edge = (state_q == S_IDLE) && rxd_p_q && !rxd_s_q;
  assign tick       = (state_q != S_IDLE) && (cnt_q == '0);
  assign smp_a      = tick && (ph_q == PH_W'(OVERSAMPLE/2 - 1));
  assign smp_b      = tick && (ph_q == PH_W'(OVERSAMPLE/2));
  assign mid        = tick && (ph_q == PH_W'(OVERSAMPLE/2 + 1));
  assign eob        = tick && (ph_q == PH_W'(OVERSAMPLE - 1));
  assign vote       = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxd_s_q) | (smp_q[1] & rxd_s_q);

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    ph_d     = ph_q;
    smp_d    = smp_q;
    sh_d     = sh_q;
    bcnt_d   = bcnt_q;
    par_d    = par_q;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    brk_d    = brk_q;
    push_req = 1'b0;
    brk_now  = 1'b0;
    if (start_edge) begin
      state_d = S_START;
      div_d   = div_eff;
      cnt_d   = div_eff - DIV_W'(1);
      ph_d    = '0;
      bcnt_d  = '0;
      par_d   = 1'b0;
      perr_d  = 1'b0;
      ferr_d  = 1'b0;
      brk_d   = 1'b0;
    end else if (state_q != S_IDLE) begin
      if (tick) begin
        cnt_d = div_q - DIV_W'(1);
        ph_d  = eob ? '0 : ph_q + PH_W'(1);
      end else begin
        cnt_d = cnt_q - DIV_W'(1);
      end
    end
    if (smp_a) smp_d[0] = rxd_s_q;
    if (smp_b) smp_d[1] = rxd_s_q;
    case (state_q)
      S_START: begin
        if (mid && vote) state_d = S_IDLE;
        else if (eob) state_d = S_DATA;
      end
      S_DATA: begin
        if (mid) begin
          sh_d   = {vote, sh_q[DATA_BITS-1:1]};
          bcnt_d = bcnt_q + 4'd1;
        end
        if (eob && bcnt_q == 4'(DATA_BITS)) begin
          bcnt_d  = '0;
          state_d = (PARITY != 0) ? S_PAR : S_STOP1;
        end
      end
      S_PAR: begin
        if (mid) begin
          par_d  = vote;
          perr_d = vote ^ (^sh_q) ^ (PARITY == 2);
        end
        if (eob) state_d = S_STOP1;
      end
      S_STOP1: begin
        if (mid) begin
          brk_now = (sh_q == '0) && (PARITY == 0 || !par_q) && !vote;
          ferr_d  = !vote || brk_now;
          brk_d   = brk_now;
          // Single stop bit: release at mid-bit so the next start edge is not missed
          if (STOP_BITS == 1) begin
            push_req = 1'b1;
            state_d  = S_IDLE;
          end
        end else if (eob && STOP_BITS == 2) begin
          state_d = S_STOP2;
        end
      end
      S_STOP2: begin
        if (mid) begin
          ferr_d   = ferr_q || !vote;
          push_req = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: ;
    endcase
  end

  assign entry      = {sh_q, perr_q, ferr_d, brk_d};
  assign empty      = (wr_q == rd_q);
  assign full       = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop        = !empty && m_ready;
  assign push       = push_req && (!full || pop);
  assign rx_overrun = push_req && full && !pop;
  assign wr_d       = wr_q + (AW+1)'(push);
  assign rd_d       = rd_q + (AW+1)'(pop);

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q[AW-1:0]] = entry;
  end

  assign head    = mem_q[rd_q[AW-1:0]];
  assign m_data  = head[EW-1:3];
  assign m_perr  = head[2];
  assign m_ferr  = head[1];
  assign m_brk   = head[0];
  assign m_valid = !empty;
  assign rx_busy = (state_q != S_IDLE);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      rxd_m_q <= 1'b1;
      rxd_s_q <= 1'b1;
      rxd_p_q <= 1'b1;
      state_q <= S_IDLE;
      div_q   <= '0;
      cnt_q   <= '0;
      ph_q    <= '0;
      smp_q   <= '0;
      sh_q    <= '0;
      bcnt_q  <= '0;
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      brk_q   <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rxd_m_q <= rxd;
      rxd_s_q <= rxd_m_q;
      rxd_p_q <= rxd_s_q;
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      ph_q    <= ph_d;
      smp_q   <= smp_d;
      sh_q    <= sh_d;
      bcnt_q  <= bcnt_d;
      par_q   <= par_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      brk_q   <= brk_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      mem_q   <= mem_d;
    end
  end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: instance A is 8N1, instance B is 8E2; both share clock and reset.
module tb_uart_rx_cfg;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        arst;
  logic [15:0] div_a, div_b;
  logic        rxd_a, rxd_b, rdy_a, rdy_b;
  logic [7:0]  a_data, b_data;
  logic        a_perr, a_ferr, a_brk, a_valid, a_busy, a_ovr;
  logic        b_perr, b_ferr, b_brk, b_valid, b_busy, b_ovr;

  uart_rx_cfg u_a (
    .clk(clk), .arst(arst), .baud_div(div_a), .rxd(rxd_a),
    .m_data(a_data), .m_perr(a_perr), .m_ferr(a_ferr), .m_brk(a_brk),
    .m_valid(a_valid), .m_ready(rdy_a), .rx_busy(a_busy), .rx_overrun(a_ovr)
  );

  uart_rx_cfg #(.PARITY(1), .STOP_BITS(2)) u_b (
    .clk(clk), .arst(arst), .baud_div(div_b), .rxd(rxd_b),
    .m_data(b_data), .m_perr(b_perr), .m_ferr(b_ferr), .m_brk(b_brk),
    .m_valid(b_valid), .m_ready(rdy_b), .rx_busy(b_busy), .rx_overrun(b_ovr)
  );

  typedef struct {
    bit         dut;
    logic [7:0] data;
    logic       par;
    logic       s1;
    logic       s2;
    logic [10:0] exp;
  } vec_t;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ovr_a = 0;
  int ra = 0;
  int rb = 0;
  logic [10:0] qa[$];
  logic [10:0] qb[$];
  int qa_t[$];
  vec_t vecs[12];
  int busy_up, busy_dn, vld_up, o0, busy_seen;
  logic [7:0] rd8;
  logic rp, rs1, rs2;
  int rdiv;

  always @(posedge clk) cyc <= cyc + 1;

  // Pop monitor: an entry is consumed at the next posedge when valid&&ready here
  always @(negedge clk) begin
    if (a_valid && rdy_a) begin
      qa.push_back({a_data, a_perr, a_ferr, a_brk});
      qa_t.push_back(cyc);
    end
    if (b_valid && rdy_b) qb.push_back({b_data, b_perr, b_ferr, b_brk});
    if (a_ovr) ovr_a++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: frame fields -> {data, perr, ferr, brk}
  function automatic logic [10:0] model(input bit dut, input logic [7:0] d, input logic p,
                                        input logic s1, input logic s2);
    logic perr, brk, ferr;
    int ones;
    ones = $countones(d);
    perr = dut ? (int'(p) != (ones % 2)) : 1'b0;
    brk  = (ones == 0) && (!dut || p == 1'b0) && (s1 == 1'b0);
    ferr = (s1 == 1'b0) || (dut && s2 == 1'b0) || brk;
    return {d, perr, ferr, brk};
  endfunction

  task automatic send(input bit dut, input logic [7:0] d, input logic p, input logic s1,
                      input logic s2, input int div, input int spk_bit, input int spk_off,
                      input int abort_at);
    logic bits [12];
    logic v;
    int n, bc, t;
    bc = 16 * ((div <= 1) ? 1 : div);
    n = 0;
    bits[n] = 1'b0; n = n + 1;
    for (int i = 0; i < 8; i++) begin bits[n] = d[i]; n = n + 1; end
    if (dut) begin bits[n] = p; n = n + 1; end
    bits[n] = s1; n = n + 1;
    if (dut) begin bits[n] = s2; n = n + 1; end
    t = 0;
    for (int b = 0; b < n; b++) begin
      for (int c = 0; c < bc; c++) begin
        if (abort_at >= 0 && t == abort_at) begin
          arst = 1'b1;
          if (dut) rxd_b = 1'b1; else rxd_a = 1'b1;
          return;
        end
        v = bits[b] ^ (b == spk_bit && c == spk_off);
        if (dut) rxd_b = v; else rxd_a = v;
        tick();
        t++;
      end
    end
    if (dut) rxd_b = 1'b1; else rxd_a = 1'b1;
    repeat (4) tick();
  endtask

  task automatic check_entry(input string name, input bit dut, input logic [10:0] exp);
    bit ok;
    logic [10:0] e;
    ok = 1'b0;
    e = '0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      if (dut ? (qb.size() > rb) : (qa.size() > ra)) begin
        ok = 1'b1;
        if (dut) begin e = qb[rb]; rb++; end
        else begin e = qa[ra]; ra++; end
      end else begin
        @(negedge clk);
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: no entry before timeout, expected %0h", name, exp);
    end else begin
      check(name, {21'd0, e}, {21'd0, exp});
    end
  endtask

  initial begin
    arst = 1'b1; rxd_a = 1'b1; rxd_b = 1'b1; rdy_a = 1'b1; rdy_b = 1'b1;
    div_a = 16'd2; div_b = 16'd2;
    vecs[0]  = '{1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, {8'hA5, 3'b000}};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, {8'h00, 3'b000}};
    vecs[2]  = '{1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, {8'hFF, 3'b010}};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, {8'h00, 3'b011}};
    vecs[4]  = '{1'b0, 8'h80, 1'b0, 1'b1, 1'b1, {8'h80, 3'b000}};
    vecs[5]  = '{1'b1, 8'h03, 1'b0, 1'b1, 1'b1, {8'h03, 3'b000}};
    vecs[6]  = '{1'b1, 8'h03, 1'b1, 1'b1, 1'b1, {8'h03, 3'b100}};
    vecs[7]  = '{1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, {8'h5A, 3'b010}};
    vecs[8]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b1, {8'h00, 3'b011}};
    vecs[9]  = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b1, {8'h00, 3'b110}};
    vecs[10] = '{1'b1, 8'h01, 1'b1, 1'b1, 1'b1, {8'h01, 3'b000}};
    vecs[11] = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b1, {8'h01, 3'b110}};

    repeat (3) tick();
    @(negedge clk);
    check("rst_a_valid", {31'd0, a_valid}, 0);
    check("rst_a_data", {24'd0, a_data}, 0);
    check("rst_a_flags", {29'd0, a_perr, a_ferr, a_brk}, 0);
    check("rst_a_busy_ovr", {30'd0, a_busy, a_ovr}, 0);
    check("rst_b_all", {18'd0, b_valid, b_data, b_perr, b_ferr, b_brk, b_busy, b_ovr}, 0);
    tick();
    arst = 1'b0;
    repeat (5) tick();

    // Latency of one 8N1 frame at 64 clk/bit with the consumer stalled
    rdy_a = 1'b0; div_a = 16'd4;
    busy_up = -1; busy_dn = -1; vld_up = -1;
    tick();
    fork
      send(1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 4, -1, 0, -1);
      begin
        for (int n = 1; n <= 800; n++) begin
          @(posedge clk);
          @(negedge clk);
          if (busy_up < 0 && a_busy) busy_up = n;
          if (busy_up >= 0 && busy_dn < 0 && !a_busy) busy_dn = n;
          if (vld_up < 0 && a_valid) vld_up = n;
        end
      end
    join
    check("busy_rise_clk", busy_up, 3);
    check("valid_rise_clk", vld_up, 3 + 9 * 64 + 10 * 4);
    check("busy_fall_clk", busy_dn, 3 + 9 * 64 + 10 * 4);
    check("head_stable", {20'd0, a_valid, a_data, a_perr, a_ferr, a_brk}, {20'd0, 1'b1, 8'hA5, 3'b000});
    rdy_a = 1'b1;
    check_entry("timing_pop", 1'b0, {8'hA5, 3'b000});

    foreach (vecs[i]) begin
      div_a = 16'd2; div_b = 16'd2;
      send(vecs[i].dut, vecs[i].data, vecs[i].par, vecs[i].s1, vecs[i].s2, 2, -1, 0, -1);
      check_entry($sformatf("vec%0d", i), vecs[i].dut, vecs[i].exp);
    end

    // Line held low 12 bit times on the 8E2 instance
    rxd_b = 1'b0;
    repeat (12 * 32) tick();
    rxd_b = 1'b1;
    repeat (64) tick();
    check_entry("break_entry", 1'b1, {8'h00, 3'b011});
    repeat (64) tick();
    check("break_single", qb.size() - rb, 0);

    // 20-clock glitch at 64 clk/bit: false start
    div_a = 16'd4; busy_seen = 0;
    for (int i = 0; i < 170; i++) begin
      rxd_a = (i < 20) ? 1'b0 : 1'b1;
      tick();
      if (a_busy) busy_seen = 1;
    end
    check("glitch_busy_seen", busy_seen, 1);
    check("glitch_idle", {31'd0, a_busy}, 0);
    check("glitch_no_entry", qa.size() - ra, 0);
    send(1'b0, 8'h0F, 1'b0, 1'b1, 1'b1, 4, 2, 35, -1);
    check_entry("spike_vote", 1'b0, {8'h0F, 3'b000});

    // Overrun: five frames into a stalled depth-4 FIFO
    rdy_a = 1'b0; div_a = 16'd2; o0 = ovr_a;
    for (int k = 1; k <= 5; k++) send(1'b0, 8'(k), 1'b0, 1'b1, 1'b1, 2, -1, 0, -1);
    repeat (20) tick();
    check("overrun_pulses", ovr_a - o0, 1);
    check("overrun_valid", {31'd0, a_valid}, 1);
    rdy_a = 1'b1;
    repeat (10) tick();
    check("drain_count", qa.size() - ra, 4);
    if (qa.size() - ra >= 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("drain_data%0d", i), {21'd0, qa[ra + i]}, {21'd0, 8'(i + 1), 3'b000});
        check($sformatf("drain_clk%0d", i), qa_t[ra + i] - qa_t[ra], i);
      end
    end
    ra = qa.size();

    // Reset mid-frame with an entry already queued
    rdy_a = 1'b0;
    send(1'b0, 8'h11, 1'b0, 1'b1, 1'b1, 2, -1, 0, -1);
    repeat (10) tick();
    check("pre_abort_valid", {31'd0, a_valid}, 1);
    send(1'b0, 8'h5A, 1'b0, 1'b1, 1'b1, 2, -1, 0, 5 * 32 + 10);
    @(negedge clk);
    check("abort_outputs", {19'd0, a_valid, a_data, a_perr, a_ferr, a_brk, a_busy, a_ovr}, 0);
    tick(); tick();
    arst = 1'b0;
    repeat (100) tick();
    check("abort_no_entry", {30'd0, a_valid, a_busy}, 0);
    check("abort_none_popped", qa.size() - ra, 0);
    rdy_a = 1'b1;
    send(1'b0, 8'h3C, 1'b0, 1'b1, 1'b1, 2, -1, 0, -1);
    check_entry("after_abort", 1'b0, {8'h3C, 3'b000});

    // Random frames and divisors on both formats
    for (int k = 0; k < 16; k++) begin
      rd8 = 8'($urandom);
      if ($urandom_range(0, 5) == 0) rd8 = 8'h00;
      rp   = 1'($urandom);
      rs1  = ($urandom_range(0, 3) != 0);
      rs2  = ($urandom_range(0, 3) != 0);
      rdiv = int'($urandom_range(0, 3));
      if (k % 2 == 1) div_b = 16'(rdiv); else div_a = 16'(rdiv);
      send(k % 2 == 1, rd8, rp, rs1, rs2, rdiv, -1, 0, -1);
      check_entry($sformatf("rand%0d", k), k % 2 == 1, model(k % 2 == 1, rd8, rp, rs1, rs2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
